// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution layer sequencer.
package conv_pkg;
    localparam int ADDR_W   = 16;
    localparam int DIM_W    = 8;
    localparam int LANES    = 4;
    localparam int PIPE_LAT = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
    typedef struct packed {
        logic [DIM_W-1:0]  m, r, c, n, i, j;
        logic [ADDR_W-1:0] ifm, row, chan, nb, nbr, w, wb, out;
    } nest_t;
endpackage

// File: rtl/conv_loop_nest.sv
// conv_loop_nest: m->r->c->n->i->j wrap counters with incrementally formed ifm/weight/out addresses.
module conv_loop_nest
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [DIM_W-1:0]  m_i,
    input  logic [DIM_W-1:0]  nw_i,
    input  logic [DIM_W-1:0]  r_i,
    input  logic [DIM_W-1:0]  c_i,
    input  logic [DIM_W-1:0]  k_i,
    input  logic [ADDR_W-1:0] w_i,
    input  logic [ADDR_W-1:0] hw_i,
    output logic              first_o,
    output logic              last_o,
    output logic              final_o,
    output logic [ADDR_W-1:0] ifm_addr_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [ADDR_W-1:0] out_addr_o
);
    localparam logic [ADDR_W-1:0] A1 = 1;
    localparam logic [DIM_W-1:0]  D1 = 1;
    nest_t s_q, s_d;
    logic jw, iw, nww, cw, rw, mw, ne;
    logic [ADDR_W-1:0] nbr_n, nb_n, chan_n, row_n;
    always_comb begin
        jw  = s_q.j == k_i - D1;
        iw  = s_q.i == k_i - D1;
        nww = s_q.n == nw_i - D1;
        cw  = s_q.c == c_i - D1;
        rw  = s_q.r == r_i - D1;
        mw  = s_q.m == m_i - D1;
        ne  = jw && iw && nww;
        // nb tracks the neuron's top-left ifm offset r*W+c; nbr tracks r*W
        nbr_n  = cw ? (rw ? '0 : s_q.nbr + w_i) : s_q.nbr;
        nb_n   = cw ? nbr_n : s_q.nb + A1;
        chan_n = nww ? nb_n : s_q.chan + hw_i;
        row_n  = iw ? chan_n : s_q.row + w_i;
        s_d = s_q;
        if (adv_i) begin
            s_d.j    = jw ? '0 : s_q.j + D1;
            s_d.i    = jw ? (iw ? '0 : s_q.i + D1) : s_q.i;
            s_d.n    = (jw && iw) ? (nww ? '0 : s_q.n + D1) : s_q.n;
            s_d.c    = ne ? (cw ? '0 : s_q.c + D1) : s_q.c;
            s_d.r    = (ne && cw) ? (rw ? '0 : s_q.r + D1) : s_q.r;
            s_d.m    = (ne && cw && rw) ? (mw ? '0 : s_q.m + D1) : s_q.m;
            s_d.ifm  = jw ? row_n : s_q.ifm + A1;
            s_d.row  = jw ? row_n : s_q.row;
            s_d.chan = (jw && iw) ? chan_n : s_q.chan;
            s_d.nb   = ne ? nb_n : s_q.nb;
            s_d.nbr  = ne ? nbr_n : s_q.nbr;
            // weights repeat per output channel; wb marks the current channel's block
            s_d.w    = (ne && !(cw && rw)) ? s_q.wb : s_q.w + A1;
            s_d.wb   = (ne && cw && rw) ? s_q.w + A1 : s_q.wb;
            s_d.out  = ne ? s_q.out + A1 : s_q.out;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_q <= '0;
        else if (clr_i) s_q <= '0;
        else s_q <= s_d;
    end
    assign first_o    = s_q.n == '0 && s_q.i == '0 && s_q.j == '0;
    assign last_o     = ne;
    assign final_o    = ne && cw && rw && mw;
    assign ifm_addr_o = s_q.ifm;
    assign w_addr_o   = s_q.w;
    assign out_addr_o = s_q.out;
endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: start/busy/done FSM, read issue gating and acc/out flag delay pipeline.
module conv_layer_sequencer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic [DIM_W-1:0]  cfg_m_i,
    input  logic [DIM_W-1:0]  cfg_nw_i,
    input  logic [DIM_W-1:0]  cfg_r_i,
    input  logic [DIM_W-1:0]  cfg_c_i,
    input  logic [DIM_W-1:0]  cfg_k_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic              ifm_en_o,
    output logic [ADDR_W-1:0] ifm_addr_o,
    output logic              w_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              acc_clear_o,
    output logic              acc_en_o,
    output logic              out_we_o,
    output logic [ADDR_W-1:0] out_addr_o
);
    localparam logic [ADDR_W-1:0] A1 = 1;
    seq_state_t state_q, state_d;
    logic [DIM_W-1:0] m_q, nw_q, r_q, c_q, k_q;
    logic [ADDR_W-1:0] w_q, hw_q, w_d, h_d;
    logic [PIPE_LAT-1:0] pv_q, pf_q, pl_q;
    logic [ADDR_W-1:0] pa_q [PIPE_LAT];
    logic [ADDR_W-1:0] ifm_a, w_a, out_a, out_addr_q;
    logic cfg_ok, launch, issue, first, last, final_i, out_we_q, cfg_err_q;
    assign cfg_ok = |cfg_m_i && |cfg_nw_i && |cfg_r_i && |cfg_c_i && |cfg_k_i;
    assign launch = state_q == IDLE && start_i && cfg_ok;
    assign issue  = state_q == RUN && !pause_i;
    assign w_d    = ADDR_W'(cfg_c_i) + ADDR_W'(cfg_k_i) - A1;
    assign h_d    = ADDR_W'(cfg_r_i) + ADDR_W'(cfg_k_i) - A1;
    conv_loop_nest u_nest (
        .clk(clk), .rst(rst), .clr_i(launch), .adv_i(issue),
        .m_i(m_q), .nw_i(nw_q), .r_i(r_q), .c_i(c_q), .k_i(k_q),
        .w_i(w_q), .hw_i(hw_q),
        .first_o(first), .last_o(last), .final_o(final_i),
        .ifm_addr_o(ifm_a), .w_addr_o(w_a), .out_addr_o(out_a)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = launch ? RUN : IDLE;
            RUN:     state_d = (issue && final_i) ? DRAIN : RUN;
            DRAIN:   state_d = (out_we_q && !(|pv_q)) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            {m_q, nw_q, r_q, c_q, k_q, w_q, hw_q} <= '0;
            {pv_q, pf_q, pl_q, out_we_q, out_addr_q, cfg_err_q} <= '0;
            for (int s = 0; s < PIPE_LAT; s++) pa_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= state_q == IDLE && start_i && !cfg_ok;
            if (launch) begin
                {m_q, nw_q, r_q, c_q, k_q} <= {cfg_m_i, cfg_nw_i, cfg_r_i, cfg_c_i, cfg_k_i};
                w_q  <= w_d;
                hw_q <= w_d * h_d;
            end
            pv_q[0] <= issue;
            pf_q[0] <= first;
            pl_q[0] <= last;
            pa_q[0] <= out_a;
            for (int s = 1; s < PIPE_LAT; s++) begin
                pv_q[s] <= pv_q[s-1];
                pf_q[s] <= pf_q[s-1];
                pl_q[s] <= pl_q[s-1];
                pa_q[s] <= pa_q[s-1];
            end
            // one cycle after the final product the accumulator holds the finished sum
            out_we_q <= pv_q[PIPE_LAT-1] && pl_q[PIPE_LAT-1];
            if (pv_q[PIPE_LAT-1] && pl_q[PIPE_LAT-1]) out_addr_q <= pa_q[PIPE_LAT-1];
        end
    end
    assign busy_o      = state_q == RUN || state_q == DRAIN;
    assign done_o      = state_q == DONE;
    assign cfg_err_o   = cfg_err_q;
    assign ifm_en_o    = issue;
    assign w_en_o      = issue;
    assign ifm_addr_o  = issue ? ifm_a : '0;
    assign w_addr_o    = issue ? w_a : '0;
    assign acc_clear_o = pv_q[PIPE_LAT-1] && pf_q[PIPE_LAT-1];
    assign acc_en_o    = pv_q[PIPE_LAT-1] && !pf_q[PIPE_LAT-1];
    assign out_we_o    = out_we_q;
    assign out_addr_o  = out_addr_q;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: scoreboard bench; expected addresses/flags queued at start, popped as the DUT emits them.
module tb_conv_layer_sequencer;
    import conv_pkg::*;
    logic clk = 0, rst = 1, start = 0, pause = 0;
    logic [DIM_W-1:0] cm = 1, cnw = 1, cr = 1, cc = 1, ck = 1;
    logic busy, done, cfg_err, ifm_en, w_en, acc_clear, acc_en, out_we;
    logic [ADDR_W-1:0] ifm_addr, w_addr, out_addr;
    logic [55:0] outs;
    int n_checks = 0, n_errors = 0;
    int q_ifm[$], q_w[$], q_out[$];
    bit q_first[$];
    int issues, n_clear, n_en, n_we, n_done, done_cyc, first_issue, last_issue;
    int clear1, we1, busy_lo, busy_hi, coincide, bubbles, overlap, base_done;

    conv_layer_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start), .pause_i(pause),
        .cfg_m_i(cm), .cfg_nw_i(cnw), .cfg_r_i(cr), .cfg_c_i(cc), .cfg_k_i(ck),
        .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
        .ifm_en_o(ifm_en), .ifm_addr_o(ifm_addr), .w_en_o(w_en), .w_addr_o(w_addr),
        .acc_clear_o(acc_clear), .acc_en_o(acc_en), .out_we_o(out_we), .out_addr_o(out_addr)
    );

    always #5 clk = ~clk;
    assign outs = {busy, done, cfg_err, ifm_en, w_en, acc_clear, acc_en, out_we, ifm_addr, w_addr, out_addr};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int m, input int nw, input int r, input int c, input int k,
                       input int p_lo, input int p_hi, input int restart);
        int h = r + k - 1, w = c + k - 1, total = m * r * c * nw * k * k, neurons = m * r * c;
        q_ifm.delete(); q_w.delete(); q_out.delete(); q_first.delete();
        for (int mi = 0; mi < m; mi++)
            for (int ri = 0; ri < r; ri++)
                for (int ci = 0; ci < c; ci++) begin
                    for (int ni = 0; ni < nw; ni++)
                        for (int ii = 0; ii < k; ii++)
                            for (int ji = 0; ji < k; ji++) begin
                                q_ifm.push_back(ni * h * w + (ri + ii) * w + (ci + ji));
                                q_w.push_back(((mi * nw + ni) * k + ii) * k + ji);
                                q_first.push_back(ni == 0 && ii == 0 && ji == 0);
                            end
                    q_out.push_back((mi * r + ri) * c + ci);
                end
        {issues, n_clear, n_en, n_we, n_done, done_cyc, first_issue, last_issue} = '0;
        {clear1, we1, busy_lo, busy_hi, coincide, bubbles, overlap} = '0;
        @(negedge clk);
        cm = DIM_W'(m); cnw = DIM_W'(nw); cr = DIM_W'(r); cc = DIM_W'(c); ck = DIM_W'(k);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            pause = cyc >= p_lo && cyc <= p_hi;
            start = cyc == restart;
            if (cyc == restart) begin cm = 7; cnw = 3; ck = 3; end
            @(negedge clk);
            if (ifm_en) begin
                issues++;
                if (first_issue == 0) first_issue = cyc;
                last_issue = cyc;
                check("w_en", w_en, 1);
                if (q_ifm.size() == 0) check("extra_issue", issues, total);
                else begin
                    check("ifm_addr", ifm_addr, q_ifm.pop_front());
                    check("w_addr", w_addr, q_w.pop_front());
                end
            end
            if (busy && pause && !ifm_en) bubbles++;
            if (acc_clear && acc_en) overlap++;
            if ((acc_clear || acc_en) && q_first.size() > 0) check("first_flag", acc_clear, q_first.pop_front());
            if (acc_clear) begin n_clear++; if (clear1 == 0) clear1 = cyc; end
            if (acc_en) n_en++;
            if (out_we) begin
                n_we++;
                if (we1 == 0) we1 = cyc;
                if (acc_clear) coincide++;
                if (q_out.size() > 0) check("out_addr", out_addr, q_out.pop_front());
            end
            if (busy) begin if (busy_lo == 0) busy_lo = cyc; busy_hi = cyc; end
            if (done) begin n_done++; done_cyc = cyc; break; end
            @(posedge clk); #1;
        end
        pause = 0;
        start = 0;
        check("done_seen", n_done, 1);
        check("issues", issues, total);
        check("acc_clear_cnt", n_clear, neurons);
        check("acc_en_cnt", n_en, total - neurons);
        check("out_we_cnt", n_we, neurons);
        check("overlap", overlap, 0);
        check("ifm_left", q_ifm.size() + q_out.size() + q_first.size(), 0);
        check("done_latency", done_cyc, last_issue + PIPE_LAT + 2);
    endtask

    initial begin
        #12;
        @(negedge clk);
        check("reset_outs", outs, 0);
        @(posedge clk); #1;
        rst = 0;

        run(1, 1, 1, 1, 1, 0, 0, 0);
        check("k1_issue_cyc", first_issue, 1);
        check("k1_clear_cyc", clear1, 3);
        check("k1_we_cyc", we1, 4);
        check("k1_done_cyc", done_cyc, 5);
        check("k1_busy_lo", busy_lo, 1);
        check("k1_busy_hi", busy_hi, 4);

        run(1, 1, 2, 2, 2, 0, 0, 0);
        check("k2_acc_en", n_en, 12);

        run(2, 2, 1, 1, 1, 0, 0, 2);
        check("m2_coincide", coincide, 1);
        base_done = done_cyc;

        run(2, 2, 1, 1, 1, 2, 4, 0);
        check("pause_bubbles", bubbles, 3);
        check("pause_done", done_cyc, base_done + 3);

        @(negedge clk);
        cm = 1; cnw = 1; cr = 1; cc = 1; ck = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_quiet", {busy, ifm_en, done}, 0);
        @(negedge clk);
        check("cfg_err_one", cfg_err, 0);
        check("cfg_err_idle", {busy, ifm_en, done}, 0);

        @(negedge clk);
        cm = 1; cnw = 1; cr = 2; cc = 2; ck = 2;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #2 rst = 1;
        #1 check("async_rst", outs, 0);
        @(posedge clk); #1;
        rst = 0;
        n_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_no_done", n_done, 0);

        run(1, 1, 2, 2, 2, 0, 0, 0);
        check("replay_first", first_issue, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
